// File: rtl/vball_color_arb_if.sv
// Palette RAM arbiter bus: three requester ports (bg, sprite, CPU) plus the RAM port.
// The arbiter connects through the slave modport; requesters and the RAM use master.
interface vball_color_arb_if;
    // Background tile engine
    logic        bg_req;
    logic [10:0] bg_addr;
    logic        bg_ack;
    logic        bg_valid;
    logic [11:0] bg_data;

    // Sprite engine
    logic        sp_req;
    logic [10:0] sp_addr;
    logic        sp_ack;
    logic        sp_valid;
    logic [11:0] sp_data;
    logic        col_busy;

    // CPU
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_valid;
    logic [11:0] cpu_rdata;

    // Palette RAM
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    modport slave (
        input  bg_req, bg_addr,
        output bg_ack, bg_valid, bg_data,
        input  sp_req, sp_addr,
        output sp_ack, sp_valid, sp_data, col_busy,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_valid, cpu_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output bg_req, bg_addr,
        input  bg_ack, bg_valid, bg_data,
        output sp_req, sp_addr,
        input  sp_ack, sp_valid, sp_data, col_busy,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_valid, cpu_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vball_color_arb.sv
// Palette RAM arbiter: one single-cycle access per clock for bg, sprite and CPU.
// Grant -> registered RAM address/ack -> owner tag stage -> data/valid to the owner.
// The palette RAM address register is ram_addr itself, so read data for a grant made
// in cycle N is on ram_rdata during N+1 and is captured at the end of N+1.
module vball_color_arb #(
    parameter int unsigned CPU_MAXWAIT = 7
) (
    input logic              clk_sys,
    input logic              reset,
    vball_color_arb_if.slave bus
);

    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagBg   = 2'd1,
        TagSp   = 2'd2,
        TagCpu  = 2'd3
    } tag_e;

    localparam logic [2:0] MaxWait = 3'(CPU_MAXWAIT);

    // Registered state
    logic        r_bg_ack;
    logic        r_sp_ack;
    logic        r_cpu_ack;
    logic        r_bg_valid;
    logic        r_sp_valid;
    logic        r_cpu_valid;
    logic [11:0] r_bg_data;
    logic [11:0] r_sp_data;
    logic [11:0] r_cpu_data;
    logic [10:0] r_ram_addr;
    logic        r_ram_we;
    logic [11:0] r_ram_wdata;
    tag_e        r_tag;
    logic [2:0]  r_cpu_wait;

    // Combinational decisions
    logic        w_bg_elig;
    logic        w_sp_elig;
    logic        w_cpu_elig;
    logic        w_cpu_forced;
    logic        w_gnt_bg;
    logic        w_gnt_sp;
    logic        w_gnt_cpu;
    logic [10:0] w_ram_addr_d;
    logic        w_ram_we_d;
    logic [11:0] w_ram_wdata_d;
    tag_e        w_tag_d;
    logic [2:0]  w_cpu_wait_d;

    // An ack-high cycle masks that requester so it cannot be granted twice for one request
    assign w_bg_elig    = bus.bg_req  & ~r_bg_ack;
    assign w_sp_elig    = bus.sp_req  & ~r_sp_ack;
    assign w_cpu_elig   = bus.cpu_req & ~r_cpu_ack;
    assign w_cpu_forced = w_cpu_elig & (r_cpu_wait == MaxWait);

    // Fixed priority: starved CPU, then bg, then sprite, then CPU
    always_comb begin
        w_gnt_bg  = 1'b0;
        w_gnt_sp  = 1'b0;
        w_gnt_cpu = 1'b0;
        if (w_cpu_forced) begin
            w_gnt_cpu = 1'b1;
        end else if (w_bg_elig) begin
            w_gnt_bg = 1'b1;
        end else if (w_sp_elig) begin
            w_gnt_sp = 1'b1;
        end else if (w_cpu_elig) begin
            w_gnt_cpu = 1'b1;
        end
    end

    // Next RAM command and owner tag for the winner; idle cycles hold the address
    always_comb begin
        w_ram_addr_d  = r_ram_addr;
        w_ram_we_d    = 1'b0;
        w_ram_wdata_d = r_ram_wdata;
        w_tag_d       = TagNone;
        if (w_gnt_bg) begin
            w_ram_addr_d  = bus.bg_addr;
            w_ram_wdata_d = bus.cpu_wdata;
            w_tag_d       = TagBg;
        end else if (w_gnt_sp) begin
            w_ram_addr_d  = bus.sp_addr;
            w_ram_wdata_d = bus.cpu_wdata;
            w_tag_d       = TagSp;
        end else if (w_gnt_cpu) begin
            w_ram_addr_d  = bus.cpu_addr;
            w_ram_we_d    = bus.cpu_we;
            w_ram_wdata_d = bus.cpu_wdata;
            // Writes return nothing, so they carry no owner tag
            w_tag_d       = bus.cpu_we ? TagNone : TagCpu;
        end
    end

    // CPU starvation counter: counts lost eligible cycles, saturates at the force level
    always_comb begin
        w_cpu_wait_d = r_cpu_wait;
        if (!bus.cpu_req || w_gnt_cpu) begin
            w_cpu_wait_d = 3'd0;
        end else if (w_cpu_elig && (r_cpu_wait != MaxWait)) begin
            w_cpu_wait_d = r_cpu_wait + 3'd1;
        end
    end

    // Stage 1: RAM command, acks, owner tag and wait counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bg_ack    <= 1'b0;
            r_sp_ack    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ram_addr  <= 11'd0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 12'd0;
            r_tag       <= TagNone;
            r_cpu_wait  <= 3'd0;
        end else begin
            r_bg_ack    <= w_gnt_bg;
            r_sp_ack    <= w_gnt_sp;
            r_cpu_ack   <= w_gnt_cpu;
            r_ram_addr  <= w_ram_addr_d;
            r_ram_we    <= w_ram_we_d;
            r_ram_wdata <= w_ram_wdata_d;
            r_tag       <= w_tag_d;
            r_cpu_wait  <= w_cpu_wait_d;
        end
    end

    // Stage 2: steer RAM read data to the tagged owner; other data outputs hold
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bg_valid  <= 1'b0;
            r_sp_valid  <= 1'b0;
            r_cpu_valid <= 1'b0;
            r_bg_data   <= 12'd0;
            r_sp_data   <= 12'd0;
            r_cpu_data  <= 12'd0;
        end else begin
            r_bg_valid  <= (r_tag == TagBg);
            r_sp_valid  <= (r_tag == TagSp);
            r_cpu_valid <= (r_tag == TagCpu);
            if (r_tag == TagBg) begin
                r_bg_data <= bus.ram_rdata;
            end
            if (r_tag == TagSp) begin
                r_sp_data <= bus.ram_rdata;
            end
            if (r_tag == TagCpu) begin
                r_cpu_data <= bus.ram_rdata;
            end
        end
    end

    assign bus.bg_ack    = r_bg_ack;
    assign bus.bg_valid  = r_bg_valid;
    assign bus.bg_data   = r_bg_data;
    assign bus.sp_ack    = r_sp_ack;
    assign bus.sp_valid  = r_sp_valid;
    assign bus.sp_data   = r_sp_data;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_valid = r_cpu_valid;
    assign bus.cpu_rdata = r_cpu_data;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_ram_wdata;

    // Sprite engine stalls while its request is outstanding and not served this cycle
    assign bus.col_busy  = bus.sp_req & ~r_sp_ack & ~w_gnt_sp;

endmodule

// File: tb/tb_vball_color_arb.sv
// Directed bench for vball_color_arb with a behavioural palette RAM.
module tb_vball_color_arb;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    vball_color_arb_if bus ();

    vball_color_arb #(
        .CPU_MAXWAIT(7)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Palette RAM: ram_addr is its address register, write-first
    logic [11:0] mem [0:2047];
    assign bus.ram_rdata = mem[bus.ram_addr];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 12'(i) ^ 12'hF00;
        end
        mem[11'h123] = 12'hABC;
        forever begin
            @(posedge clk_sys);
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_reqs();
        bus.bg_req  = 1'b0;
        bus.sp_req  = 1'b0;
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        bus.bg_req    = 1'b1;
        bus.bg_addr   = 11'h000;
        bus.sp_req    = 1'b1;
        bus.sp_addr   = 11'h001;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 11'h002;
        bus.cpu_wdata = 12'h000;

        // Reset held 3 cycles with every request asserted
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_acks", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'd0);
            check("rst_valids", {29'd0, bus.bg_valid, bus.sp_valid, bus.cpu_valid}, 32'd0);
            check("rst_ram", {20'd0, bus.ram_we, bus.ram_addr}, 32'd0);
            check("rst_data", {bus.bg_data, bus.sp_data, bus.cpu_rdata[7:0]}, 32'd0);
        end
        reset = 1'b0;
        check("rel_bg_ack", 32'(bus.bg_ack), 32'd0);
        step();
        check("rel_bg_ack1", 32'(bus.bg_ack), 32'd1);
        check("rel_sp_ack1", 32'(bus.sp_ack), 32'd0);
        check("rel_no_valid", {29'd0, bus.bg_valid, bus.sp_valid, bus.cpu_valid}, 32'd0);
        idle_reqs();
        step();
        check("rel_bg_valid", 32'(bus.bg_valid), 32'd1);
        check("rel_bg_data", 32'(bus.bg_data), 32'hF00);
        check("rel_sp_ack2", 32'(bus.sp_ack), 32'd0);
        step();
        step();

        // Single background read
        bus.bg_req  = 1'b1;
        bus.bg_addr = 11'h123;
        step();
        check("bg_ram_addr", 32'(bus.ram_addr), 32'h123);
        check("bg_ack", 32'(bus.bg_ack), 32'd1);
        check("bg_ram_we", 32'(bus.ram_we), 32'd0);
        bus.bg_req = 1'b0;
        step();
        check("bg_valid", 32'(bus.bg_valid), 32'd1);
        check("bg_data", 32'(bus.bg_data), 32'hABC);
        check("bg_ack_drop", 32'(bus.bg_ack), 32'd0);
        check("bg_sp_valid", 32'(bus.sp_valid), 32'd0);
        step();
        check("bg_valid_pulse", 32'(bus.bg_valid), 32'd0);

        // Priority: bg, sp, bg again, cpu read
        bus.bg_req   = 1'b1;
        bus.bg_addr  = 11'h010;
        bus.sp_req   = 1'b1;
        bus.sp_addr  = 11'h020;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h030;
        #1;
        check("pri_col_busy0", 32'(bus.col_busy), 32'd1);
        step();
        check("pri_acks1", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'b100);
        check("pri_addr1", 32'(bus.ram_addr), 32'h010);
        bus.bg_addr = 11'h011;
        #1;
        check("pri_col_busy1", 32'(bus.col_busy), 32'd0);
        step();
        check("pri_acks2", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'b010);
        check("pri_addr2", 32'(bus.ram_addr), 32'h020);
        check("pri_bg_data2", {19'd0, bus.bg_valid, bus.bg_data}, {19'd0, 1'b1, 12'hF10});
        bus.sp_req = 1'b0;
        step();
        check("pri_acks3", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'b100);
        check("pri_addr3", 32'(bus.ram_addr), 32'h011);
        check("pri_sp_data3", {19'd0, bus.sp_valid, bus.sp_data}, {19'd0, 1'b1, 12'hF20});
        bus.bg_req = 1'b0;
        step();
        check("pri_acks4", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'b001);
        check("pri_addr4", 32'(bus.ram_addr), 32'h030);
        check("pri_bg_data4", {19'd0, bus.bg_valid, bus.bg_data}, {19'd0, 1'b1, 12'hF11});
        bus.cpu_req = 1'b0;
        step();
        check("pri_cpu_data5", {19'd0, bus.cpu_valid, bus.cpu_rdata}, {19'd0, 1'b1, 12'hF30});
        check("pri_acks5", {29'd0, bus.bg_ack, bus.sp_ack, bus.cpu_ack}, 32'd0);
        step();
        step();

        // CPU starvation under continuous bg + sp traffic; forced write
        bus.sp_req    = 1'b1;
        bus.sp_addr   = 11'h040;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h7FF;
        bus.cpu_wdata = 12'h5A5;
        bus.bg_req    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                step();
            end
            bus.bg_addr = 11'h100 + 11'(k);
            #1;
            check($sformatf("starve_col_busy%0d", k), 32'(bus.col_busy),
                  32'((k == 0) || (k == 7)));
            check($sformatf("starve_cpu_ack%0d", k), 32'(bus.cpu_ack), 32'd0);
            check($sformatf("starve_ram_we%0d", k), 32'(bus.ram_we), 32'd0);
        end
        step();
        check("starve_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        check("starve_ram_we", 32'(bus.ram_we), 32'd1);
        check("starve_ram_addr", 32'(bus.ram_addr), 32'h7FF);
        check("starve_ram_wdata", 32'(bus.ram_wdata), 32'h5A5);
        bus.bg_req  = 1'b0;
        bus.cpu_req = 1'b0;
        bus.sp_addr = 11'h7FF;
        step();
        check("wr_we_once", 32'(bus.ram_we), 32'd0);
        check("wr_sp_ack", 32'(bus.sp_ack), 32'd1);
        check("wr_sp_addr", 32'(bus.ram_addr), 32'h7FF);
        check("wr_no_cpu_valid", 32'(bus.cpu_valid), 32'd0);
        bus.sp_req = 1'b0;
        step();
        check("wr_readback", {19'd0, bus.sp_valid, bus.sp_data}, {19'd0, 1'b1, 12'h5A5});
        check("wr_no_cpu_valid2", 32'(bus.cpu_valid), 32'd0);
        step();
        step();

        // Reset during an in-flight sprite read
        bus.sp_req  = 1'b1;
        bus.sp_addr = 11'h055;
        step();
        check("mid_sp_ack", 32'(bus.sp_ack), 32'd1);
        reset      = 1'b1;
        bus.sp_req = 1'b0;
        step();
        check("mid_sp_valid", 32'(bus.sp_valid), 32'd0);
        check("mid_sp_data", 32'(bus.sp_data), 32'd0);
        check("mid_ram_addr", 32'(bus.ram_addr), 32'd0);
        reset = 1'b0;
        step();
        check("mid_sp_valid2", 32'(bus.sp_valid), 32'd0);
        check("mid_sp_data2", 32'(bus.sp_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vball_color_arb.md
# vball_color_arb

Arbiter and sequencer for the shared 2048×12 palette (color) RAM. It serves three requesters: the background tile engine, the sprite engine and the CPU. Each cycle it grants one single-cycle RAM access, pipelines read data back to the owner, and generates `col_busy` for the sprite engine. It sits between the video engines (background, `vball_sprites`), the CPU bus decode, and the palette RAM instance.

## Interface
Parameters:
- CPU_MAXWAIT, 7: number of consecutive lost cycles after which a pending CPU request is forced to win.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- bg_req  in  1  background read request (level)
- bg_addr  in  11  background palette address
- bg_ack  out  1  background request accepted (1-cycle pulse)
- bg_valid  out  1  bg_data valid (1-cycle pulse)
- bg_data  out  12  background read data
- sp_req  in  1  sprite read request (level)
- sp_addr  in  11  sprite palette address (`sca`)
- sp_ack  out  1  sprite request accepted (pulse)
- sp_valid  out  1  sp_data valid (pulse)
- sp_data  out  12  sprite read data (`scd`)
- col_busy  out  1  sp_req pending and not granted this cycle
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  11  CPU palette address
- cpu_wdata  in  12  CPU write data
- cpu_ack  out  1  CPU access accepted (pulse)
- cpu_valid  out  1  cpu_rdata valid (pulse; reads only)
- cpu_rdata  out  12  CPU read data
- ram_addr  out  11  palette RAM address (registered)
- ram_we  out  1  palette RAM write enable (registered)
- ram_wdata  out  12  palette RAM write data (registered)
- ram_rdata  in  12  palette RAM data; synchronous, 1 cycle after ram_addr

## Operation
- Eligibility in cycle N: a requester is eligible if its req=1 and its ack is 0 in cycle N. An ack-high cycle masks that requester's req, which prevents a double grant while it drops or updates its request.
- Priority among eligible requesters: forced CPU (cpu_wait == CPU_MAXWAIT) > bg > sp > cpu. Exactly one grant per cycle, or none.
- Grant in cycle N registers the following at edge end of N:
  - ram_addr is set to the winner's address.
  - ram_we is set to (winner==cpu && cpu_we), and ram_wdata is set to cpu_wdata.
  - The winner's ack is set to 1.
  - A 2-bit owner tag (0 none, 1 bg, 2 sp, 3 cpu-read) is pushed into stage 1. A CPU write pushes tag 0.
- No grant: ram_we is 0, ram_addr holds its value, and tag 0 is pushed.
- Stage 2 (edge end of N+1): ram_rdata is latched into the data output of the stage-1 tag owner and that owner's valid pulses. Data outputs of the other requesters hold their previous value.
- cpu_wait is a 3-bit counter:
  - +1 (saturating at CPU_MAXWAIT) each cycle the CPU is eligible and not granted.
  - Cleared on CPU grant, and cleared whenever cpu_req=0.
- col_busy is combinational: sp_req & ~sp_ack & ~(sp granted this cycle).
- Writes and reads to the same address in consecutive grants: the read granted at N+1 after a write granted at N returns the new data, because the RAM is write-first and the arbiter adds no bypass.

## Timing
- Reset value of every output is 0: all acks, valids, data buses, ram_addr, ram_we, ram_wdata. Pipeline tags and cpu_wait are also cleared to 0.
- Reset asserted mid-transfer drops in-flight reads. No valid pulses in the cycle after reset deasserts.
- Read latency from grant cycle N: ack at N+1, valid and data at N+2. Throughput is 1 access/cycle.
- Write: ram_we is high during N+1 only; cpu_ack at N+1; cpu_valid is never pulsed.
- bg holding req continuously with a fresh address is granted every other cycle (ack masks alternate cycles). sp and cpu fill the gaps.
- With bg and sp both continuously requesting, the CPU is granted no later than CPU_MAXWAIT+1 cycles after cpu_req rises.
- Simultaneous forced CPU and bg: CPU wins. bg is granted in the next cycle.

## Test plan
- Reset: hold reset 3 cycles with all reqs=1 → all outputs 0 and no ack during reset. First bg_ack appears 1 cycle after reset falls.
- Single bg read: RAM[0x123]=0xABC, bg_req@N addr 0x123 → ram_addr=0x123@N+1, bg_ack@N+1, bg_valid with bg_data=0xABC@N+2.
- Priority: bg, sp and cpu-read all req@N → bg@N, sp@N+1, bg(again)@N+2, cpu@N+3. The valids arrive in the same order, 2 cycles after each grant.
- col_busy: sp_req high while bg holds req → col_busy=1 on bg-grant cycles, 0 on the sp-grant cycle.
- CPU starvation: bg and sp continuously requesting, cpu write 0x7FF←0x5A5 → forced grant within 8 cycles. ram_we=1 for exactly 1 cycle; a subsequent sp read of 0x7FF returns 0x5A5.
- Reset mid-read: grant sp read@N, reset@N+1 → no sp_valid at N+2 and sp_data=0.
